// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline.
// It keeps a shadow copy of the EX/MEM/WB destination info and produces
// ID-stage forward selects, load-use stalls, branch flushes and memory-wait
// freezes, plus a saturating count of cycles the PC did not advance.
module hazard_fwd_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             ID_Rn,
    input  logic [3:0]             ID_Rm,
    input  logic [3:0]             ID_Rd,
    input  logic                   ID_use_Rn,
    input  logic                   ID_use_Rm,
    input  logic                   ID_use_Rd,
    input  logic                   ID_RF,
    input  logic                   ID_load_instr,
    input  logic                   ID_B,
    input  logic                   MEM_busy,
    output logic                   PC_LE,
    output logic                   IFID_LE,
    output logic                   IFID_clear,
    output logic                   IDEX_nop,
    output logic                   PIPE_hold,
    output logic [1:0]             FW_A,
    output logic [1:0]             FW_B,
    output logic [1:0]             FW_C,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t state;

    // Shadow pipeline: _p0 = EX, _p1 = MEM, _p2 = WB
    logic       vld_p0, vld_p1, vld_p2;
    logic [3:0] rd_p0, rd_p1, rd_p2;
    logic       wr_p0, wr_p1, wr_p2;
    logic       ld_p0, ld_p1, ld_p2;

    logic load_use;
    logic advance;

    // Saturating increment for the stall counter
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Forward select for one operand; youngest writer wins, R15 never forwards.
    // A load still in EX cannot supply data, so that match yields RF (stall covers it).
    function automatic logic [1:0] fwd_sel(input logic [3:0] r, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && r != 4'd15) begin
            if (vld_p0 && wr_p0 && rd_p0 == r)
                sel = ld_p0 ? 2'b00 : 2'b01;
            else if (vld_p1 && wr_p1 && rd_p1 == r)
                sel = 2'b10;
            else if (vld_p2 && wr_p2 && rd_p2 == r)
                sel = 2'b11;
        end
        return sel;
    endfunction

    assign load_use = vld_p0 && ld_p0 && wr_p0 &&
                      ((ID_use_Rn && ID_Rn == rd_p0) ||
                       (ID_use_Rm && ID_Rm == rd_p0) ||
                       (ID_use_Rd && ID_Rd == rd_p0));

    assign advance = !reset && !MEM_busy;

    // Control outputs: reset override, then freeze, then load-use, then branch
    always_comb begin
        PC_LE      = 1'b1;
        IFID_LE    = 1'b1;
        IFID_clear = 1'b0;
        IDEX_nop   = 1'b0;
        PIPE_hold  = 1'b0;
        FW_A       = fwd_sel(ID_Rn, ID_use_Rn);
        FW_B       = fwd_sel(ID_Rm, ID_use_Rm);
        FW_C       = fwd_sel(ID_Rd, ID_use_Rd);
        if (reset) begin
            PC_LE      = 1'b0;
            IFID_LE    = 1'b0;
            IFID_clear = 1'b1;
            IDEX_nop   = 1'b1;
            FW_A       = 2'b00;
            FW_B       = 2'b00;
            FW_C       = 2'b00;
        end else if (MEM_busy) begin
            PC_LE     = 1'b0;
            IFID_LE   = 1'b0;
            PIPE_hold = 1'b1;
        end else if (load_use) begin
            PC_LE    = 1'b0;
            IFID_LE  = 1'b0;
            IDEX_nop = 1'b1;
        end else if (ID_B) begin
            IFID_clear = 1'b1;
        end
    end

    // Control state: FSM, stall counter and shadow valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            stall_count <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
        end else begin
            case (state)
                RUN:     state <= MEM_busy ? HOLD : RUN;
                HOLD:    state <= MEM_busy ? HOLD : RUN;
                default: state <= RUN;
            endcase
            if (!PC_LE)
                stall_count <= sat_inc(stall_count);
            if (!MEM_busy) begin
                vld_p0 <= !IDEX_nop;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
            end
        end
    end

    // Shadow data fields advance with the pipeline; meaningful only when valid
    always_ff @(posedge clk) begin
        if (advance) begin
            rd_p0 <= ID_Rd;
            wr_p0 <= ID_RF;
            ld_p0 <= ID_load_instr;
            rd_p1 <= rd_p0;
            wr_p1 <= wr_p0;
            ld_p1 <= ld_p0;
            rd_p2 <= rd_p1;
            wr_p2 <= wr_p1;
            ld_p2 <= ld_p1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for hazard_fwd_ctrl: each cycle's expected
// control word is queued when the ID inputs are driven and compared mid-cycle.
module tb_hazard_fwd_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ID_Rn, ID_Rm, ID_Rd;
    logic          ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic          ID_RF, ID_load_instr, ID_B, MEM_busy;
    logic          PC_LE, IFID_LE, IFID_clear, IDEX_nop, PIPE_hold;
    logic [1:0]    FW_A, FW_B, FW_C;
    logic [CW-1:0] stall_count;

    typedef struct {
        logic pc_le, ifid_le, ifid_clear, idex_nop, pipe_hold;
        int   fa, fb, fc;   // -1 = not checked
        int   cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    hazard_fwd_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
        .ID_RF(ID_RF), .ID_load_instr(ID_load_instr), .ID_B(ID_B),
        .MEM_busy(MEM_busy),
        .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_clear(IFID_clear),
        .IDEX_nop(IDEX_nop), .PIPE_hold(PIPE_hold),
        .FW_A(FW_A), .FW_B(FW_B), .FW_C(FW_C),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL c%0d %s: got %0h expected %0h", cyc, tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                         input logic un, input logic um, input logic ud,
                         input logic rf, input logic ld, input logic b);
        ID_Rn = rn; ID_Rm = rm; ID_Rd = rd;
        ID_use_Rn = un; ID_use_Rm = um; ID_use_Rd = ud;
        ID_RF = rf; ID_load_instr = ld; ID_B = b;
    endtask

    // Queue the expected word, compare at the falling edge, then step past the next rising edge
    task automatic expect_cyc(input logic pc, input logic le, input logic clr,
                              input logic nop, input logic hold,
                              input int fa, input int fb, input int fc, input int cnt);
        exp_t e;
        exp_t g;
        e.pc_le = pc; e.ifid_le = le; e.ifid_clear = clr; e.idex_nop = nop; e.pipe_hold = hold;
        e.fa = fa; e.fb = fb; e.fc = fc; e.cnt = cnt;
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        chk("PC_LE",      32'(PC_LE),      32'(g.pc_le));
        chk("IFID_LE",    32'(IFID_LE),    32'(g.ifid_le));
        chk("IFID_clear", 32'(IFID_clear), 32'(g.ifid_clear));
        chk("IDEX_nop",   32'(IDEX_nop),   32'(g.idex_nop));
        chk("PIPE_hold",  32'(PIPE_hold),  32'(g.pipe_hold));
        if (g.fa >= 0) chk("FW_A", 32'(FW_A), 32'(g.fa));
        if (g.fb >= 0) chk("FW_B", 32'(FW_B), 32'(g.fb));
        if (g.fc >= 0) chk("FW_C", 32'(FW_C), 32'(g.fc));
        chk("stall_count", 32'(stall_count), 32'(g.cnt));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        MEM_busy = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        // reset values
        expect_cyc(0, 0, 1, 1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        // ADD R1 ; SUB R4,R1 -> EX forward
        drive(2, 3, 1, 1, 1, 0, 1, 0, 0);  expect_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 4, 1, 1, 0, 1, 0, 0);  expect_cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
        // LDR R2 reading R1 from MEM
        drive(6, 1, 2, 1, 1, 0, 1, 1, 0);  expect_cyc(1, 1, 0, 0, 0, 0, 2, 0, 0);
        // ADD R7,R4,R2: load-use stall, then MEM forward of the load
        drive(4, 2, 7, 1, 1, 0, 1, 0, 0);  expect_cyc(0, 0, 0, 1, 0, 2, -1, 0, 0);
        expect_cyc(1, 1, 0, 0, 0, 3, 2, 0, 1);
        // R3 written by EX, MEM and WB
        drive(0, 0, 3, 0, 0, 0, 1, 0, 0);  expect_cyc(1, 1, 0, 0, 0, 0, 0, 0, 1);
        drive(3, 0, 3, 1, 0, 0, 1, 0, 0);  expect_cyc(1, 1, 0, 0, 0, 1, 0, 0, 1);
        expect_cyc(1, 1, 0, 0, 0, 1, 0, 0, 1);
        // STR reads R3 on Rn and Rd, R15 on Rm
        drive(3, 15, 3, 1, 1, 1, 0, 0, 0); expect_cyc(1, 1, 0, 0, 0, 1, 0, 1, 1);
        // EX holds a non-writing STR, R3 comes from MEM
        drive(3, 0, 9, 1, 0, 0, 1, 1, 0);  expect_cyc(1, 1, 0, 0, 0, 2, 0, 0, 1);
        // ADD R15,R9,R3: stall on R9, R3 from WB; then bubble in EX
        drive(9, 3, 15, 1, 1, 0, 1, 0, 0); expect_cyc(0, 0, 0, 1, 0, -1, 3, 0, 1);
        expect_cyc(1, 1, 0, 0, 0, 2, 0, 0, 2);
        // Branch reading R15 (written in EX): no forward, flush
        drive(15, 10, 0, 1, 1, 0, 0, 0, 1); expect_cyc(1, 1, 1, 0, 0, 0, 0, 0, 2);
        drive(0, 0, 4, 0, 0, 0, 1, 1, 0);  expect_cyc(1, 1, 0, 0, 0, 0, 0, 0, 2);
        // Branch during load-use stall is ignored, then taken on re-decode
        drive(4, 0, 6, 1, 0, 0, 1, 0, 1);  expect_cyc(0, 0, 0, 1, 0, -1, 0, 0, 2);
        expect_cyc(1, 1, 1, 0, 0, 2, 0, 0, 3);
        // LDR R5, then a dependent ADD frozen by MEM_busy for 3 cycles
        drive(0, 0, 5, 0, 0, 0, 1, 1, 0);  expect_cyc(1, 1, 0, 0, 0, 0, 0, 0, 3);
        drive(5, 6, 11, 1, 1, 0, 1, 0, 0);
        MEM_busy = 1'b1;
        expect_cyc(0, 0, 0, 0, 1, -1, 2, 0, 3);
        expect_cyc(0, 0, 0, 0, 1, -1, 2, 0, 4);
        expect_cyc(0, 0, 0, 0, 1, -1, 2, 0, 5);
        MEM_busy = 1'b0;
        expect_cyc(0, 0, 0, 1, 0, -1, 2, 0, 6);
        expect_cyc(1, 1, 0, 0, 0, 2, 3, 0, 7);
        // Hold, then reset asserted while holding
        drive(11, 5, 0, 1, 1, 0, 0, 0, 0);
        MEM_busy = 1'b1;
        expect_cyc(0, 0, 0, 0, 1, 1, 3, 0, 7);
        reset = 1'b1;
        expect_cyc(0, 0, 1, 1, 0, 0, 0, 0, 8);
        reset = 1'b0;
        MEM_busy = 1'b0;
        expect_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller for the five-stage ARM-subset pipeline (IF, ID, EX, MEM, WB). It tracks destination-register information for the EX, MEM and WB stages in an internal shadow pipeline. It generates the decode-stage forwarding selects and handles three sequencing cases: load-use stalls, branch flushes and data-memory wait holds. It sits beside the ID-stage control unit, consumes that unit's decoded signals, and drives the latch enables and NOP muxes of the pipeline registers.

## Interface
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ID_Rn, ID_Rm, ID_Rd  in  4 each  register fields of the instruction in ID
- ID_use_Rn, ID_use_Rm, ID_use_Rd  in  1 each  operand actually read (ID_use_Rd = store data)
- ID_RF  in  1  ID instruction writes Rd
- ID_load_instr  in  1  ID instruction is a load
- ID_B  in  1  branch taken in ID (already condition-qualified)
- MEM_busy  in  1  data memory not ready; whole pipeline must freeze
- PC_LE, IFID_LE  out  1 each  latch enables for PC and IF/ID
- IFID_clear  out  1  load NOP into IF/ID at the next edge
- IDEX_nop  out  1  select NOP control word into ID/EX
- PIPE_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- FW_A, FW_B, FW_C  out  2 each  forward select for Rn, Rm, Rd: 00 RF, 01 EX out, 10 MEM out, 11 WB out
- stall_count  out  STALL_CNT_W  saturating count of stalled or held cycles

## Operation
- Shadow pipeline: three entries {valid, rd[3:0], wr, load} for EX, MEM and WB.
- On an advancing edge:
  - EX takes the ID info, or a bubble (valid=0) when IDEX_nop=1.
  - MEM takes EX.
  - WB takes MEM.
- FSM states: RUN, HOLD.
  - RUN→HOLD when MEM_busy=1.
  - HOLD→RUN on the first cycle MEM_busy=0.
  - The state is registered. Output override below is combinational on MEM_busy, so the freeze starts the same cycle.
- Freeze, whenever MEM_busy=1:
  - PC_LE=0, IFID_LE=0, PIPE_hold=1, IDEX_nop=0, IFID_clear=0.
  - Shadow pipeline holds.
  - Forward selects keep being computed from the held shadow state.
- Load-use stall (MEM_busy=0): asserted when the EX entry is valid, load=1, wr=1, and its rd equals any used ID source.
  - PC_LE=0, IFID_LE=0, IDEX_nop=1, PIPE_hold=0.
  - Exactly one bubble is inserted. Next cycle the load is in MEM and the operand forwards with 10.
- Branch (MEM_busy=0, no load-use stall): ID_B=1 drives IFID_clear=1 and PC_LE=1.
  - A branch that coincides with a load-use stall is ignored that cycle. It is re-evaluated when the instruction re-decodes.
- Forwarding, per used operand:
  - Compare against EX, then MEM, then WB entries that have valid=1 and wr=1. The first match wins (priority EX > MEM > WB).
  - EX match on a load entry never yields 01; that case is covered by the stall.
  - No match, operand unused, or register 15: select 00.
- Normal run: PC_LE=1, IFID_LE=1, all other control outputs 0.
- stall_count increments by 1 on every edge where PC_LE=0 and reset=0, saturating at all-ones.

## Timing
- While reset=1 (combinational override):
  - PC_LE=0, IFID_LE=0, IFID_clear=1, IDEX_nop=1, PIPE_hold=0, FW_*=00.
- At the reset edge:
  - Shadow entries are cleared to valid=0.
  - State goes to RUN and stall_count to 0.
- Reset asserted mid-stall or mid-hold: the override applies that same cycle, and the first cycle after reset is RUN.
- All control outputs are combinational from the ID inputs, the shadow regs and MEM_busy; the shadow pipeline and counter are registered.
- Latency: forward selects are valid in the same cycle the instruction is in ID. A load-use stall costs exactly 1 cycle; a branch costs 1 flushed slot.
- MEM_busy high for N cycles gives exactly N frozen cycles. The shadow pipeline does not advance, and stall_count advances N.
- MEM_busy coinciding with a load-use condition: the freeze wins. The stall is applied after release, still exactly one bubble.

## Test plan
- Reset, then ADD R1 in EX, SUB using Rn=R1 in ID -> FW_A=01, PC_LE=1, IDEX_nop=0.
- LDR R2 in EX, ADD with Rm=R2 in ID -> one cycle of PC_LE=0, IFID_LE=0, IDEX_nop=1. Next cycle FW_B=10, stall_count=1.
- R3 written by the instructions in EX, MEM and WB, ID reads R3 on Rn and Rd -> FW_A=01, FW_C=01. Bubble EX -> FW_A=10. ID reading R15 -> FW=00.
- ID_B=1 with no hazard -> IFID_clear=1 for one cycle, PC_LE=1. ID_B=1 during a load-use stall -> IFID_clear=0.
- MEM_busy=1 for 3 cycles during a load-use condition -> PIPE_hold=1 ×3, then one bubble. stall_count=4, shadow contents unchanged across the hold.
- Assert reset during a hold -> outputs take the reset values that cycle. After release the FSM is in RUN, stall_count=0, FW_*=00.
